// File: rtl/result_drain.sv
// Drains collector result elements over a four-phase handshake into a FIFO and
// re-emits them as a valid/ready stream, closing each multiply with a ticks trailer.
module result_drain #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_ELEMS  = 256,
  parameter int MAT_DIM    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        elem_rdy,
  input  logic [31:0] acc,
  input  logic [4:0]  rrow,
  input  logic [4:0]  rcol,
  input  logic        mm_done,
  input  logic [31:0] ticks,
  output logic        ack_elem,
  output logic        ack_ticks,
  output logic [31:0] dout,
  output logic [4:0]  dout_row,
  output logic [4:0]  dout_col,
  output logic        dout_last,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        count_err,
  output logic        order_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {I_IDLE, I_ACK} istate_t;
  typedef enum logic {T_RUN, T_ACK} tstate_t;

  istate_t        istate_q, istate_d;
  tstate_t        tstate_q, tstate_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [8:0]     elem_cnt_q, elem_cnt_d;
  logic [4:0]     exp_row_q, exp_row_d;
  logic [4:0]     exp_col_q, exp_col_d;
  logic           count_err_q, count_err_d;
  logic           order_err_q, order_err_d;
  logic [42:0]    mem_q [FIFO_DEPTH];

  logic        full, empty, pop, elem_push, trl_push, push;
  logic [42:0] push_word, head;

  assign full  = (occ_q == CW'(FIFO_DEPTH));
  assign empty = (occ_q == '0);
  assign pop   = !empty && dout_ready;

  // The intake and the trailer are mutually exclusive through elem_rdy, so the
  // element always wins without an explicit arbiter.
  assign elem_push = (istate_q == I_IDLE) && elem_rdy && !full;
  assign trl_push  = (tstate_q == T_RUN) && mm_done && (istate_q == I_IDLE)
                     && !elem_rdy && !full;
  assign push      = elem_push || trl_push;
  assign push_word = elem_push ? {1'b0, rrow, rcol, acc} : {1'b1, 10'd0, ticks};

  always_comb begin
    istate_d    = istate_q;
    tstate_d    = tstate_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    elem_cnt_d  = elem_cnt_q;
    exp_row_d   = exp_row_q;
    exp_col_d   = exp_col_q;
    count_err_d = count_err_q;
    order_err_d = order_err_q;

    case (istate_q)
      I_IDLE: if (elem_push) istate_d = I_ACK;
      I_ACK:  if (!elem_rdy) istate_d = I_IDLE;
      default: istate_d = I_IDLE;
    endcase

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    // Expected raster position advances on every element, even a misplaced one.
    if (elem_push) begin
      elem_cnt_d = elem_cnt_q + 9'd1;
      if (rrow != exp_row_q || rcol != exp_col_q) order_err_d = 1'b1;
      if (exp_col_q == 5'(MAT_DIM - 1)) begin
        exp_col_d = '0;
        exp_row_d = exp_row_q + 5'd1;
      end else begin
        exp_col_d = exp_col_q + 5'd1;
      end
    end

    case (tstate_q)
      T_RUN: begin
        if (trl_push) begin
          tstate_d = T_ACK;
          if (elem_cnt_q != 9'(NUM_ELEMS)) count_err_d = 1'b1;
        end
      end
      T_ACK: begin
        if (!mm_done) begin
          tstate_d   = T_RUN;
          elem_cnt_d = '0;
          exp_row_d  = '0;
          exp_col_d  = '0;
        end
      end
      default: tstate_d = T_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istate_q    <= I_IDLE;
      tstate_q    <= T_RUN;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      elem_cnt_q  <= '0;
      exp_row_q   <= '0;
      exp_col_q   <= '0;
      count_err_q <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      istate_q    <= istate_d;
      tstate_q    <= tstate_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      elem_cnt_q  <= elem_cnt_d;
      exp_row_q   <= exp_row_d;
      exp_col_q   <= exp_col_d;
      count_err_q <= count_err_d;
      order_err_q <= order_err_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once occupancy is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_word;
  end

  assign head       = empty ? 43'd0 : mem_q[rptr_q];
  assign dout       = head[31:0];
  assign dout_col   = head[36:32];
  assign dout_row   = head[41:37];
  assign dout_last  = head[42];
  assign dout_valid = !empty;
  assign ack_elem   = (istate_q == I_ACK);
  assign ack_ticks  = (tstate_q == T_ACK);
  assign count_err  = count_err_q;
  assign order_err  = order_err_q;

endmodule

// File: tb/tb_result_drain.sv
// Randomized bench for result_drain: a queue model of the emitted stream plus
// sticky-flag model, checked every cycle, with directed handshake scenarios.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        elem_rdy;
  logic [31:0] acc;
  logic [4:0]  rrow, rcol;
  logic        mm_done;
  logic [31:0] ticks;
  logic        ack_elem, ack_ticks;
  logic [31:0] dout;
  logic [4:0]  dout_row, dout_col;
  logic        dout_last, dout_valid, dout_ready;
  logic        count_err, order_err;

  result_drain #(.FIFO_DEPTH(8), .NUM_ELEMS(256), .MAT_DIM(16)) dut (
    .clk(clk), .reset(reset), .elem_rdy(elem_rdy), .acc(acc), .rrow(rrow),
    .rcol(rcol), .mm_done(mm_done), .ticks(ticks), .ack_elem(ack_elem),
    .ack_ticks(ack_ticks), .dout(dout), .dout_row(dout_row), .dout_col(dout_col),
    .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .count_err(count_err), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [31:0] data;
  } word_t;

  word_t       expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          idx = 0;
  int          cnt = 0;
  bit          mOrder = 0;
  bit          mCount = 0;
  bit          randReady = 0;
  int          popCount = 0;
  logic [31:0] lastData = '0;
  logic        lastLast = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs only change 1ns after rising edges.
  always @(negedge clk) begin
    word_t w;
    checkOutput("dout_valid", dout_valid, expQ.size() != 0);
    if (dout_valid && expQ.size() != 0) begin
      w = expQ[0];
      checkOutput("dout", dout, w.data);
      checkOutput("dout_row", dout_row, w.row);
      checkOutput("dout_col", dout_col, w.col);
      checkOutput("dout_last", dout_last, w.last);
      if (dout_ready) begin
        void'(expQ.pop_front());
        popCount++;
        lastData = dout;
        lastLast = dout_last;
      end
    end else if (!dout_valid) begin
      checkOutput("empty_dout", dout, 0);
      checkOutput("empty_last", dout_last, 0);
      checkOutput("empty_rowcol", {dout_row, dout_col}, 0);
    end
    checkOutput("count_err", count_err, mCount);
    checkOutput("order_err", order_err, mOrder);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic waitAckElem(input logic v);
    int n = 0;
    while (ack_elem !== v && n < 200) begin tick(); n++; end
    if (ack_elem !== v) checkOutput("ack_elem_timeout", ack_elem, v);
  endtask

  task automatic waitAckTicks(input logic v);
    int n = 0;
    while (ack_ticks !== v && n < 200) begin tick(); n++; end
    if (ack_ticks !== v) checkOutput("ack_ticks_timeout", ack_ticks, v);
  endtask

  task automatic applyStimulus(input int r, input int c, input logic [31:0] a);
    rrow = 5'(r);
    rcol = 5'(c);
    acc = a;
    elem_rdy = 1'b1;
  endtask

  task automatic modelElem(input int r, input int c, input logic [31:0] a);
    expQ.push_back({1'b0, 5'(r), 5'(c), a});
    if (r != idx / 16 || c != idx % 16) mOrder = 1;
    idx++;
    cnt++;
  endtask

  task automatic completeElem(input int r, input int c, input logic [31:0] a);
    modelElem(r, c, a);
    elem_rdy = 1'b0;
    waitAckElem(1'b0);
  endtask

  task automatic sendElem(input int r, input int c, input logic [31:0] a);
    applyStimulus(r, c, a);
    waitAckElem(1'b1);
    completeElem(r, c, a);
  endtask

  task automatic finishTrailer(input logic [31:0] t);
    waitAckTicks(1'b1);
    expQ.push_back({1'b1, 5'd0, 5'd0, t});
    if (cnt != 256) mCount = 1;
    mm_done = 1'b0;
    waitAckTicks(1'b0);
    cnt = 0;
    idx = 0;
  endtask

  task automatic sendTrailer(input logic [31:0] t);
    mm_done = 1'b1;
    ticks = t;
    finishTrailer(t);
  endtask

  task automatic drain();
    int n = 0;
    randReady = 0;
    dout_ready = 1'b1;
    while (expQ.size() != 0 && n < 100) begin tick(); n++; end
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  task automatic doReset();
    tick();
    #2;
    reset = 1'b1;
    expQ.delete();
    mOrder = 0; mCount = 0; idx = 0; cnt = 0;
    elem_rdy = 1'b0;
    mm_done = 1'b0;
    #1;
    checkOutput("rst_ack_elem", ack_elem, 0);
    checkOutput("rst_ack_ticks", ack_ticks, 0);
    checkOutput("rst_valid", dout_valid, 0);
    checkOutput("rst_last", dout_last, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_rowcol", {dout_row, dout_col}, 0);
    checkOutput("rst_count_err", count_err, 0);
    checkOutput("rst_order_err", order_err, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; elem_rdy = 1'b0; acc = '0; rrow = '0; rcol = '0;
    mm_done = 1'b0; ticks = '0; dout_ready = 1'b0;
    #3;
    checkOutput("init_valid", dout_valid, 0);
    checkOutput("init_acks", {ack_elem, ack_ticks}, 0);
    checkOutput("init_errs", {count_err, order_err}, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Full raster multiply with an always-ready sink.
    dout_ready = 1'b1;
    popCount = 0;
    for (int i = 0; i < 256; i++) sendElem(i / 16, i % 16, 32'(i));
    sendTrailer(32'd1234);
    drain();
    checkOutput("raster_pops", popCount, 257);
    checkOutput("raster_trailer_data", lastData, 1234);
    checkOutput("raster_trailer_last", lastLast, 1);
    checkOutput("raster_errs", {count_err, order_err}, 0);

    // Backpressure: eight words fill the FIFO, the ninth waits for a pop.
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) sendElem(0, i, $urandom);
    t = $urandom;
    applyStimulus(0, 8, t);
    repeat (4) begin
      tick();
      checkOutput("full_no_ack", ack_elem, 0);
    end
    dout_ready = 1'b1;
    tick();
    checkOutput("pop_edge_no_ack", ack_elem, 0);
    tick();
    checkOutput("ack_after_pop", ack_elem, 1);
    completeElem(0, 8, t);

    // Remaining elements under random backpressure, last one racing mm_done.
    randReady = 1;
    for (int i = 9; i < 255; i++) sendElem(i / 16, i % 16, $urandom);
    t = $urandom;
    applyStimulus(15, 15, $urandom);
    mm_done = 1'b1;
    ticks = t;
    begin
      int n = 0;
      while (ack_elem !== 1'b1 && n < 200) begin
        tick(); n++;
        checkOutput("ack_ticks_early", ack_ticks, 0);
      end
      checkOutput("last_elem_ack", ack_elem, 1);
      modelElem(15, 15, acc);
      elem_rdy = 1'b0;
      n = 0;
      while (ack_elem !== 1'b0 && n < 200) begin
        tick(); n++;
        checkOutput("ack_ticks_before_drop", ack_ticks, 0);
      end
    end
    finishTrailer(t);
    drain();
    checkOutput("race_errs", {count_err, order_err}, 0);

    // Short multiply: 255 elements flags a count error.
    randReady = 1;
    for (int i = 0; i < 255; i++) sendElem(i / 16, i % 16, $urandom);
    sendTrailer($urandom);
    drain();
    checkOutput("short_count_err", count_err, 1);
    checkOutput("short_order_err", order_err, 0);
    doReset();

    // Swapped pair: both words still emitted, order error raised.
    dout_ready = 1'b1;
    popCount = 0;
    sendElem(0, 0, 32'h10);
    sendElem(0, 1, 32'h11);
    sendElem(0, 3, 32'h13);
    sendElem(0, 2, 32'h12);
    drain();
    checkOutput("swap_pops", popCount, 4);
    checkOutput("swap_last_data", lastData, 32'h12);
    checkOutput("swap_order_err", order_err, 1);
    doReset();

    // Reset with five words buffered; next run restarts at (0,0).
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) sendElem(0, i, $urandom);
    checkOutput("mid_ack_ticks", ack_ticks, 0);
    checkOutput("mid_valid_before", dout_valid, 1);
    doReset();
    checkOutput("mid_valid_after", dout_valid, 0);
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) sendElem(0, i, $urandom);
    drain();
    checkOutput("restart_order_err", order_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Downstream consumer of the collector stage of the parallel matrix-multiply datapath. It drains finished result elements (acc, rrow, rcol) over the four-phase elem_rdy/ack_elem handshake into a small FIFO, then re-emits them as a valid/ready stream. When mm_done is signalled it appends a trailer word carrying the latency tick count and completes the ack_ticks handshake. It also checks element count and raster order, and flags any mismatch.

## Interface

Parameters:
- FIFO_DEPTH, 8, entries in the result FIFO; power of two, ≥2.
- NUM_ELEMS, 256, elements expected per multiply (16x16).
- MAT_DIM, 16, row/column dimension used for the raster-order check.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- elem_rdy  in  1  collector has a valid element on acc/rrow/rcol.
- acc  in  32  element value.
- rrow  in  5  element row index.
- rcol  in  5  element column index.
- mm_done  in  1  collector reports the multiply is complete.
- ticks  in  32  latency count, stable while mm_done is high.
- ack_elem  out  1  element-accepted acknowledge (four-phase).
- ack_ticks  out  1  trailer-accepted acknowledge (four-phase).
- dout  out  32  stream data: element value, or ticks in the trailer.
- dout_row  out  5  row of the head word (0 in the trailer).
- dout_col  out  5  column of the head word (0 in the trailer).
- dout_last  out  1  head word is the trailer.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  downstream accepts the head word.
- count_err  out  1  sticky: element count at mm_done ≠ NUM_ELEMS.
- order_err  out  1  sticky: element arrived out of raster order.

## Operation

- FIFO entry is 43 bits: {last, row, col, data}. Storage is registered. The head word is presented combinationally from the read pointer. dout_valid = (occupancy ≠ 0).
- Pop: occurs on dout_valid & dout_ready.
- Push: blocked whenever the FIFO is full, including in a cycle where a pop also occurs. When not full, a simultaneous push and pop is legal and occupancy is unchanged.
- Intake FSM:
  - I_IDLE: if elem_rdy=1 and the FIFO is not full, push {0, rrow, rcol, acc}, increment elem_cnt (9 bits), set ack_elem=1 and go to I_ACK. If the FIFO is full, stay in I_IDLE with ack_elem=0; the collector holds its data.
  - I_ACK: hold ack_elem=1 until elem_rdy is sampled 0, then clear ack_elem and go to I_IDLE.
- Order check: the expected (row, col) starts at (0,0) and advances col; when col reaches MAT_DIM-1 it wraps to 0 and row increments. Any pushed element that differs from the expected position sets order_err. The expected index advances on every push regardless of a mismatch.
- Trailer FSM:
  - T_RUN: if mm_done=1, intake is in I_IDLE, elem_rdy=0 and the FIFO is not full, then:
    - push {1, 0, 0, ticks};
    - set count_err if elem_cnt ≠ NUM_ELEMS;
    - set ack_ticks=1 and go to T_ACK.
  - T_ACK: hold ack_ticks=1 until mm_done is sampled 0, then clear ack_ticks, clear elem_cnt and the expected index, and go to T_RUN.
- Priority: an element intake always beats the trailer. A trailer is never pushed in the same cycle as an element.
- Sticky errors clear only on reset.
- Reset mid-operation: the FIFO empties and all FSMs return to I_IDLE/T_RUN. Words in flight are discarded and never emitted.

## Timing

- Reset values: ack_elem=0, ack_ticks=0, dout_valid=0, dout_last=0, dout/dout_row/dout_col=0 (empty FIFO reads as zero), count_err=0, order_err=0.
- Element accept latency:
  - elem_rdy sampled high at edge k with the FIFO not full: ack_elem and dout_valid are both high after edge k.
  - Minimum handshake is 2 cycles per element, the second cycle spent waiting for elem_rdy to fall.
- Trailer: pushed at the first edge where all T_RUN conditions hold. ack_ticks is high after that edge.
- Pop: the head pointer advances at the edge where valid & ready. The next word (or dout_valid=0) is visible after that edge.
- Throughput: the output side can sustain one word per cycle. The input side is limited to one element per two cycles by the handshake.

## Test plan

- Reset check: assert reset asynchronously mid-cycle. All outputs must go to 0 immediately, with no clock edge required.
- Raster stream: 256 elements (row r, col c, acc = r*16+c), dout_ready=1, then mm_done with ticks=1234:
  - output is 256 words in order, then a trailer with dout=1234 and dout_last=1;
  - count_err=0 and order_err=0.
- Backpressure: dout_ready=0 with FIFO_DEPTH=8:
  - the 9th elem_rdy receives no ack_elem;
  - raising dout_ready drains word (0,0) first, and ack_elem for element 9 follows on the next edge.
- Simultaneous events: mm_done rises while elem_rdy is high for the last element:
  - the element is pushed before the trailer;
  - ack_ticks stays 0 until elem_rdy=0 and ack_elem has dropped.
- Error flags:
  - send only 255 elements, then mm_done: count_err=1;
  - swap two elements, (0,3) sent before (0,2): order_err=1 and both words are still emitted.
- Reset mid-transfer: assert reset while the FIFO holds 5 words and ack_ticks=0:
  - dout_valid=0 after reset;
  - the next run starts its order check at (0,0).
